// File: rtl/npu_mac_seq.sv
// Job sequencer in front of the MAC cell: pairs activation/weight streams, feeds LEN products,
// collects the requantized result on a valid/ready port and clears the accumulator per output.
module npu_mac_seq #(
  parameter int I_LEN   = 8,
  parameter int O_LEN   = 8,
  parameter int CNT_W   = 16,
  parameter int RES_LAT = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic [CNT_W-1:0] n_out_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  input  logic             a_valid_i,
  input  logic [I_LEN-1:0] a_data_i,
  output logic             a_ready_o,
  input  logic             w_valid_i,
  input  logic [I_LEN-1:0] w_data_i,
  output logic             w_ready_o,
  output logic             mac_t0_v_o,
  output logic [I_LEN-1:0] mac_t0_o,
  output logic             mac_t1_v_o,
  output logic [I_LEN-1:0] mac_t1_o,
  output logic             mac_clear_o,
  input  logic             mac_t2_v_i,
  input  logic [O_LEN-1:0] mac_t2_i,
  output logic             res_valid_o,
  output logic [O_LEN-1:0] res_data_o,
  input  logic             res_ready_i
);

  // state   | meaning
  // S_IDLE  | waiting for a start with non-zero LEN and N_OUT
  // S_CLR   | one-cycle accumulator clear; then RUN, or IDLE after the last output
  // S_RUN   | streaming paired operands into the MAC until LEN fires
  // S_DRAIN | waiting RES_LAT cycles for the MAC result, then sampling it
  // S_OUT   | presenting the result until the downstream accepts it
  typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_DRAIN, S_OUT} state_e;

  localparam int LAT_W = (RES_LAT > 1) ? $clog2(RES_LAT) : 1;

  state_e           state_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] k_q;
  logic [CNT_W-1:0] rem_q;
  logic [LAT_W-1:0] lat_q;
  logic [O_LEN-1:0] res_data_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             clr_q;
  logic             res_valid_q;
  logic             fire;

  // Both streams move together or not at all, and only while running.
  assign fire = (state_q == S_RUN) & a_valid_i & w_valid_i;

  assign a_ready_o   = fire;
  assign w_ready_o   = fire;
  assign mac_t0_v_o  = fire;
  assign mac_t1_v_o  = fire;
  assign mac_t0_o    = fire ? a_data_i : '0;
  assign mac_t1_o    = fire ? w_data_i : '0;
  assign mac_clear_o = clr_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      k_q         <= '0;
      rem_q       <= '0;
      lat_q       <= '0;
      res_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      clr_q       <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      clr_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (len_i != '0 && n_out_i != '0) begin
              len_q   <= len_i;
              rem_q   <= n_out_i;
              clr_q   <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= S_CLR;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_CLR: begin
          if (rem_q != '0) begin
            k_q     <= len_q;
            state_q <= S_RUN;
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          if (fire) begin
            k_q <= k_q - CNT_W'(1);
            if (k_q == CNT_W'(1)) begin
              lat_q   <= LAT_W'(RES_LAT - 1);
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (lat_q == '0) begin
            res_data_q  <= mac_t2_i;
            res_valid_q <= 1'b1;
            err_q       <= ~mac_t2_v_i;
            state_q     <= S_OUT;
          end else begin
            lat_q <= lat_q - LAT_W'(1);
          end
        end
        S_OUT: begin
          if (res_ready_i) begin
            res_valid_q <= 1'b0;
            rem_q       <= rem_q - CNT_W'(1);
            clr_q       <= 1'b1;
            state_q     <= S_CLR;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_npu_mac_seq.sv
// Bench for npu_mac_seq: a behavioural MAC model plus randomized streams, results compared
// against dot products computed directly from the operand vectors.
module tb_npu_mac_seq;
  localparam int I_LEN   = 8;
  localparam int O_LEN   = 8;
  localparam int CNT_W   = 16;
  localparam int RES_LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_i = 1'b1;
  logic             start_i = 1'b0;
  logic [CNT_W-1:0] len_i = '0;
  logic [CNT_W-1:0] n_out_i = '0;
  logic             busy_o, done_o, err_o;
  logic             a_valid_i = 1'b0;
  logic [I_LEN-1:0] a_data_i = '0;
  logic             a_ready_o;
  logic             w_valid_i = 1'b0;
  logic [I_LEN-1:0] w_data_i = '0;
  logic             w_ready_o;
  logic             mac_t0_v_o, mac_t1_v_o, mac_clear_o;
  logic [I_LEN-1:0] mac_t0_o, mac_t1_o;
  logic             mac_t2_v_i;
  logic [O_LEN-1:0] mac_t2_i;
  logic             res_valid_o;
  logic [O_LEN-1:0] res_data_o;
  logic             res_ready_i = 1'b0;

  npu_mac_seq #(.I_LEN(I_LEN), .O_LEN(O_LEN), .CNT_W(CNT_W), .RES_LAT(RES_LAT)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .len_i(len_i), .n_out_i(n_out_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .a_valid_i(a_valid_i), .a_data_i(a_data_i), .a_ready_o(a_ready_o),
    .w_valid_i(w_valid_i), .w_data_i(w_data_i), .w_ready_o(w_ready_o),
    .mac_t0_v_o(mac_t0_v_o), .mac_t0_o(mac_t0_o), .mac_t1_v_o(mac_t1_v_o), .mac_t1_o(mac_t1_o),
    .mac_clear_o(mac_clear_o), .mac_t2_v_i(mac_t2_v_i), .mac_t2_i(mac_t2_i),
    .res_valid_o(res_valid_o), .res_data_o(res_data_o), .res_ready_i(res_ready_i)
  );

  int tests = 0;
  int fails = 0;

  function automatic logic [7:0] sat8(input int v);
    if (v > 127) return 8'h7f;
    if (v < -128) return 8'h80;
    return v[7:0];
  endfunction

  // MAC cell model: clear wins, products accumulate, result valid one cycle after a product.
  int   acc = 0;
  logic t2v_q = 1'b0;
  bit   t2_en = 1'b1;
  always @(posedge clk) begin
    if (mac_clear_o) acc <= 0;
    else if (mac_t0_v_o) acc <= acc + int'($signed(mac_t0_o)) * int'($signed(mac_t1_o));
    t2v_q <= mac_t0_v_o & t2_en;
  end
  assign mac_t2_v_i = t2v_q;
  assign mac_t2_i   = sat8(acc);

  // Passive monitor, sampled on the falling edge.
  int         mon_cyc = 0, mon_clr = 0, mon_fire = 0, mon_done = 0, mon_err = 0;
  int         mon_side = 0, mon_unstable = 0, mon_out_act = 0, done_cyc = 0, res_cnt = 0;
  logic [7:0] res_log [0:255];
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  always @(negedge clk) begin
    mon_cyc++;
    if (mac_clear_o) mon_clr++;
    if (mac_t0_v_o) mon_fire++;
    if (done_o) begin mon_done++; done_cyc = mon_cyc; end
    if (err_o) mon_err++;
    if ((a_ready_o !== w_ready_o) || (mac_t0_v_o !== a_ready_o) || (mac_t1_v_o !== a_ready_o) ||
        (a_ready_o && !(a_valid_i && w_valid_i))) mon_side++;
    if (a_ready_o && (mac_t0_o !== a_data_i || mac_t1_o !== w_data_i)) mon_side++;
    if (!a_ready_o && (mac_t0_o !== '0 || mac_t1_o !== '0)) mon_side++;
    if (res_valid_o && (a_ready_o || mac_clear_o)) mon_out_act++;
    if (prev_stall && (res_valid_o !== 1'b1 || res_data_o !== prev_data)) mon_unstable++;
    prev_stall = res_valid_o && !res_ready_i;
    prev_data  = res_data_o;
    if (res_valid_o && res_ready_i) begin
      res_log[res_cnt[7:0]] = res_data_o;
      res_cnt++;
    end
  end

  logic [7:0] a_vec[$];
  logic [7:0] w_vec[$];

  function automatic logic [7:0] ref_dot(input int o, input int len);
    int s = 0;
    for (int k = 0; k < len; k++)
      s += int'($signed(a_vec[o*len+k])) * int'($signed(w_vec[o*len+k]));
    return sat8(s);
  endfunction

  task automatic fill_random(input int total);
    a_vec.delete();
    w_vec.delete();
    for (int i = 0; i < total; i++) begin
      a_vec.push_back(8'($urandom_range(0, 255)));
      w_vec.push_back(8'($urandom_range(0, 255)));
    end
  endtask

  // Runs one job to its done pulse (bounded). phase: cycles of out-of-phase valids;
  // hold: result cycles with ready forced low; restart_at: loop cycle that re-pulses start.
  task automatic drive_job(input int len, input int nout, input int vpct, input int rpct,
                           input int phase, input int hold, input int restart_at,
                           output int c0, output int phase_fire, output bit to);
    int ai = 0, cyc = 0, hold_left = hold, d0, total;
    total = len * nout;
    phase_fire = 0;
    to = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b1; len_i = CNT_W'(len); n_out_i = CNT_W'(nout);
    d0 = mon_done;
    @(posedge clk); #1;
    start_i = 1'b0;
    c0 = mon_cyc;
    while (mon_done == d0) begin
      if (cyc >= 4000) begin to = 1'b1; break; end
      start_i = (cyc == restart_at);
      if (cyc == restart_at) begin len_i = CNT_W'(9); n_out_i = CNT_W'(4); end
      if (cyc < phase) begin
        a_valid_i = cyc[0];
        w_valid_i = ~cyc[0];
      end else begin
        a_valid_i = (ai < total) && ($urandom_range(99) < vpct);
        w_valid_i = (ai < total) && ($urandom_range(99) < vpct);
      end
      a_data_i = (ai < total) ? a_vec[ai] : '0;
      w_data_i = (ai < total) ? w_vec[ai] : '0;
      res_ready_i = (hold_left > 0) ? 1'b0 : ($urandom_range(99) < rpct);
      @(negedge clk);
      if (cyc < phase && (a_ready_o || w_ready_o)) phase_fire++;
      if (a_ready_o) ai++;
      if (res_valid_o && hold_left > 0) hold_left--;
      @(posedge clk); #1;
      cyc++;
    end
    start_i = 1'b0; a_valid_i = 1'b0; w_valid_i = 1'b0; res_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; a_valid_i = 1'b1; w_valid_i = 1'b1; res_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    tests++; if (a_ready_o !== 1'b0 || w_ready_o !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b%b expected 00", a_ready_o, w_ready_o); end
    tests++; if ({mac_t0_v_o, mac_t1_v_o, mac_clear_o} !== 3'b000) begin fails++; $display("FAIL reset_mac: got %b expected 000", {mac_t0_v_o, mac_t1_v_o, mac_clear_o}); end
    tests++; if ({done_o, err_o, res_valid_o} !== 3'b000 || res_data_o !== '0) begin fails++; $display("FAIL reset_res: got %b/%0d expected 000/0", {done_o, err_o, res_valid_o}, res_data_o); end
    @(posedge clk); #1;
    rst_i = 1'b0; a_valid_i = 1'b0; w_valid_i = 1'b0; res_ready_i = 1'b0;
    @(negedge clk);
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_idle_busy: got %b expected 0", busy_o); end
  endtask

  task automatic test_basic();
    int c0, pf, r0, cl0, f0, e0, s0; bit to;
    a_vec = '{8'd2, 8'd3, 8'd4};
    w_vec = '{8'd1, 8'd1, 8'd1};
    r0 = res_cnt; cl0 = mon_clr; f0 = mon_fire; e0 = mon_err; s0 = mon_side;
    drive_job(3, 1, 100, 100, 0, 0, -1, c0, pf, to);
    tests++; if (to !== 1'b0) begin fails++; $display("FAIL basic_timeout: got %b expected 0", to); end
    tests++; if (res_cnt - r0 != 1) begin fails++; $display("FAIL basic_count: got %0d expected 1", res_cnt - r0); end
    tests++; if (res_log[r0[7:0]] !== 8'd9) begin fails++; $display("FAIL basic_result: got %0d expected 9", res_log[r0[7:0]]); end
    tests++; if (mon_clr - cl0 != 2) begin fails++; $display("FAIL basic_clears: got %0d expected 2", mon_clr - cl0); end
    tests++; if (mon_fire - f0 != 3) begin fails++; $display("FAIL basic_fires: got %0d expected 3", mon_fire - f0); end
    tests++; if (done_cyc != c0 + 2 + (3 + RES_LAT + 2)) begin fails++; $display("FAIL basic_latency: got %0d expected %0d", done_cyc - c0, 2 + 3 + RES_LAT + 2); end
    tests++; if (mon_err != e0 || mon_side != s0) begin fails++; $display("FAIL basic_err_side: got %0d/%0d expected 0/0", mon_err - e0, mon_side - s0); end
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL basic_busy_after: got %b expected 0", busy_o); end
  endtask

  task automatic test_valid_phase();
    int c0, pf, r0, f0, s0; bit to;
    a_vec = '{8'd2, 8'd3, 8'd4};
    w_vec = '{8'd1, 8'd1, 8'd1};
    r0 = res_cnt; f0 = mon_fire; s0 = mon_side;
    drive_job(3, 1, 100, 100, 10, 0, -1, c0, pf, to);
    tests++; if (to !== 1'b0) begin fails++; $display("FAIL phase_timeout: got %b expected 0", to); end
    tests++; if (pf != 0) begin fails++; $display("FAIL phase_fire: got %0d expected 0", pf); end
    tests++; if (res_log[r0[7:0]] !== 8'd9 || res_cnt - r0 != 1) begin fails++; $display("FAIL phase_result: got %0d (n=%0d) expected 9 (n=1)", res_log[r0[7:0]], res_cnt - r0); end
    tests++; if (mon_side != s0 || mon_fire - f0 != 3) begin fails++; $display("FAIL phase_side: got side=%0d fires=%0d expected 0/3", mon_side - s0, mon_fire - f0); end
  endtask

  task automatic test_multi_stall();
    int c0, pf, r0, cl0, f0, u0, o0; bit to;
    fill_random(6);
    r0 = res_cnt; cl0 = mon_clr; f0 = mon_fire; u0 = mon_unstable; o0 = mon_out_act;
    drive_job(2, 3, 100, 100, 0, 5, -1, c0, pf, to);
    tests++; if (to !== 1'b0) begin fails++; $display("FAIL stall_timeout: got %b expected 0", to); end
    tests++; if (res_cnt - r0 != 3) begin fails++; $display("FAIL stall_count: got %0d expected 3", res_cnt - r0); end
    for (int o = 0; o < 3; o++) begin
      tests++;
      if (res_log[8'(r0 + o)] !== ref_dot(o, 2)) begin fails++; $display("FAIL stall_result%0d: got %0d expected %0d", o, res_log[8'(r0 + o)], ref_dot(o, 2)); end
    end
    tests++; if (mon_clr - cl0 != 4) begin fails++; $display("FAIL stall_clears: got %0d expected 4", mon_clr - cl0); end
    tests++; if (mon_unstable != u0 || mon_out_act != o0) begin fails++; $display("FAIL stall_hold: got unstable=%0d act=%0d expected 0/0", mon_unstable - u0, mon_out_act - o0); end
    tests++; if (done_cyc != c0 + 2 + 3 * (2 + RES_LAT + 2) + 5 || mon_fire - f0 != 6) begin fails++; $display("FAIL stall_latency: got %0d fires=%0d expected %0d fires=6", done_cyc - c0, mon_fire - f0, 2 + 3 * (2 + RES_LAT + 2) + 5); end
  endtask

  task automatic test_zero_start();
    int e0, cl0;
    e0 = mon_err; cl0 = mon_clr;
    for (int v = 0; v < 2; v++) begin
      @(posedge clk); #1;
      start_i = 1'b1;
      len_i   = (v == 0) ? CNT_W'(0) : CNT_W'(3);
      n_out_i = (v == 0) ? CNT_W'(2) : CNT_W'(0);
      @(posedge clk); #1;
      start_i = 1'b0;
      @(negedge clk);
      tests++; if (err_o !== 1'b1 || busy_o !== 1'b0) begin fails++; $display("FAIL zero_start%0d: got err=%b busy=%b expected 1/0", v, err_o, busy_o); end
      @(negedge clk);
      tests++; if (err_o !== 1'b0 || busy_o !== 1'b0) begin fails++; $display("FAIL zero_after%0d: got err=%b busy=%b expected 0/0", v, err_o, busy_o); end
    end
    tests++; if (mon_err - e0 != 2 || mon_clr != cl0) begin fails++; $display("FAIL zero_counts: got err=%0d clr=%0d expected 2/0", mon_err - e0, mon_clr - cl0); end
  endtask

  task automatic test_reset_mid();
    int c0, pf, r0, d0, f0; bit to;
    d0 = mon_done;
    @(posedge clk); #1;
    start_i = 1'b1; len_i = CNT_W'(4); n_out_i = CNT_W'(1);
    a_valid_i = 1'b1; w_valid_i = 1'b1; a_data_i = 8'd7; w_data_i = 8'd3;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    tests++; if (a_ready_o !== 1'b0 || mac_clear_o !== 1'b1) begin fails++; $display("FAIL mid_clr: got ready=%b clear=%b expected 0/1", a_ready_o, mac_clear_o); end
    @(negedge clk);
    tests++; if (a_ready_o !== 1'b1) begin fails++; $display("FAIL mid_fire: got %b expected 1", a_ready_o); end
    @(posedge clk); #1;
    a_valid_i = 1'b0; w_valid_i = 1'b0; rst_i = 1'b1;
    @(posedge clk); #1;
    a_valid_i = 1'b1; w_valid_i = 1'b1;
    @(negedge clk);
    tests++; if ({busy_o, a_ready_o, w_ready_o, mac_t0_v_o, mac_clear_o, res_valid_o, done_o, err_o} !== 8'h00) begin
      fails++; $display("FAIL mid_reset_outputs: got %b expected 00000000", {busy_o, a_ready_o, w_ready_o, mac_t0_v_o, mac_clear_o, res_valid_o, done_o, err_o});
    end
    @(posedge clk); #1;
    rst_i = 1'b0; a_valid_i = 1'b0; w_valid_i = 1'b0;
    a_vec = '{8'd5};
    w_vec = '{8'd2};
    r0 = res_cnt; f0 = mon_fire;
    drive_job(1, 1, 100, 100, 0, 0, -1, c0, pf, to);
    tests++; if (to !== 1'b0 || res_log[r0[7:0]] !== 8'd10 || res_cnt - r0 != 1) begin fails++; $display("FAIL mid_newjob: got %0d (n=%0d) expected 10 (n=1)", res_log[r0[7:0]], res_cnt - r0); end
    tests++; if (mon_done - d0 != 1 || mon_fire - f0 != 1) begin fails++; $display("FAIL mid_pulses: got done=%0d fires=%0d expected 1/1", mon_done - d0, mon_fire - f0); end
  endtask

  task automatic test_restart_drain();
    int c0, pf, r0, cl0, f0, e0; bit to;
    fill_random(4);
    r0 = res_cnt; cl0 = mon_clr; f0 = mon_fire; e0 = mon_err;
    drive_job(2, 2, 100, 100, 0, 0, 3, c0, pf, to);
    tests++; if (to !== 1'b0 || res_cnt - r0 != 2) begin fails++; $display("FAIL restart_count: got %0d expected 2", res_cnt - r0); end
    for (int o = 0; o < 2; o++) begin
      tests++;
      if (res_log[8'(r0 + o)] !== ref_dot(o, 2)) begin fails++; $display("FAIL restart_result%0d: got %0d expected %0d", o, res_log[8'(r0 + o)], ref_dot(o, 2)); end
    end
    tests++; if (mon_fire - f0 != 4 || mon_clr - cl0 != 3 || mon_err != e0) begin fails++; $display("FAIL restart_counts: got fires=%0d clr=%0d err=%0d expected 4/3/0", mon_fire - f0, mon_clr - cl0, mon_err - e0); end
    tests++; if (done_cyc != c0 + 2 + 2 * (2 + RES_LAT + 2)) begin fails++; $display("FAIL restart_latency: got %0d expected %0d", done_cyc - c0, 2 + 2 * (2 + RES_LAT + 2)); end
  endtask

  task automatic test_t2_missing();
    int c0, pf, r0, e0; bit to;
    fill_random(3);
    t2_en = 1'b0;
    r0 = res_cnt; e0 = mon_err;
    drive_job(3, 1, 100, 100, 0, 0, -1, c0, pf, to);
    t2_en = 1'b1;
    tests++; if (to !== 1'b0 || mon_err - e0 != 1) begin fails++; $display("FAIL t2_err: got %0d expected 1", mon_err - e0); end
    tests++; if (res_log[r0[7:0]] !== ref_dot(0, 3)) begin fails++; $display("FAIL t2_data: got %0d expected %0d", res_log[r0[7:0]], ref_dot(0, 3)); end
  endtask

  task automatic test_random();
    int c0, pf, r0, cl0, s0, u0, len, nout; bit to;
    for (int j = 0; j < 6; j++) begin
      len  = int'($urandom_range(1, 6));
      nout = int'($urandom_range(1, 3));
      fill_random(len * nout);
      r0 = res_cnt; cl0 = mon_clr; s0 = mon_side; u0 = mon_unstable;
      drive_job(len, nout, 50, 50, 0, 0, -1, c0, pf, to);
      tests++; if (to !== 1'b0 || res_cnt - r0 != nout) begin fails++; $display("FAIL rand%0d_count: got %0d expected %0d", j, res_cnt - r0, nout); end
      for (int o = 0; o < nout; o++) begin
        tests++;
        if (res_log[8'(r0 + o)] !== ref_dot(o, len)) begin fails++; $display("FAIL rand%0d_result%0d: got %0d expected %0d", j, o, res_log[8'(r0 + o)], ref_dot(o, len)); end
      end
      tests++; if (mon_clr - cl0 != nout + 1 || mon_side != s0 || mon_unstable != u0) begin
        fails++; $display("FAIL rand%0d_proto: got clr=%0d side=%0d unstable=%0d expected %0d/0/0", j, mon_clr - cl0, mon_side - s0, mon_unstable - u0, nout + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_valid_phase();
    test_multi_stall();
    test_zero_start();
    test_reset_mid();
    test_restart_drain();
    test_t2_missing();
    test_random();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
